// File: rtl/fa_3_seq_pkg.sv
// Shared definitions for the sequential chunked adder.
//   SLICE_W      width of one adder slice (bits per chunk)
//   seq_state_t  controller state encoding
//   idx_width()  width of the chunk index counter for a given chunk count
package fa_3_seq_pkg;

  localparam int SLICE_W = 3;

  typedef enum logic [1:0] {
    IDLE,
    ADD,
    DONE
  } seq_state_t;

  // ceil(log2(n)), never below 1 so a single-chunk build still has an index bit.
  function automatic int idx_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/fa_3.sv
// 3-bit full-adder slice: {cout, s} = a + b + cin.
//   a, b  3-bit addends
//   cin   carry-in
//   s     3-bit sum
//   cout  carry-out
module fa_3 (
  input  logic [2:0] a,
  input  logic [2:0] b,
  input  logic       cin,
  output logic [2:0] s,
  output logic       cout
);

  assign {cout, s} = {1'b0, a} + {1'b0, b} + {3'b000, cin};

endmodule

// File: rtl/fa_3_seq_ctrl.sv
// Multi-cycle wide adder: one fa_3 slice is reused over NCHUNK clocks, LSB
// chunk first, with the carry chained through a register.
//   clk, rst_n           clock, asynchronous active-low reset
//   in_valid / in_ready  operand handshake (in_ready registered)
//   in_a, in_b, in_cin   operands, sampled only on the accept edge
//   out_valid/out_ready  result handshake (out_valid registered)
//   out_sum, out_cout    registered result, qualified by out_valid
//   busy                 high while an operation is in ADD or DONE
module fa_3_seq_ctrl
  import fa_3_seq_pkg::*;
#(
  parameter  int NCHUNK = 4,
  localparam int W      = SLICE_W * NCHUNK
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_a,
  input  logic [W-1:0] in_b,
  input  logic         in_cin,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_sum,
  output logic         out_cout,
  output logic         busy
);

  localparam int IW = idx_width(NCHUNK);

  seq_state_t   state, next_state;
  logic [W-1:0] a_q, b_q;
  logic         carry_q;
  logic [IW-1:0] idx;

  logic [SLICE_W-1:0] slice_s;
  logic               slice_cout;
  logic               accept;
  logic               last_chunk;

  assign accept     = (state == IDLE) && in_valid && in_ready;
  assign last_chunk = (idx == IW'(NCHUNK - 1));
  assign busy       = (state != IDLE);

  fa_3 u_fa_3 (
    .a    (a_q[idx*SLICE_W +: SLICE_W]),
    .b    (b_q[idx*SLICE_W +: SLICE_W]),
    .cin  (carry_q),
    .s    (slice_s),
    .cout (slice_cout)
  );

  // NOTE: next_state gets a default before the case so no path leaves it
  // unassigned; an unassigned path in always_comb would infer a latch.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (accept)     next_state = ADD;
      ADD:     if (last_chunk) next_state = DONE;
      DONE:    if (out_ready)  next_state = IDLE;
      default:                 next_state = IDLE;
    endcase
  end

  // NOTE: every flop here, operand registers included, is reset so a dropped
  // operation leaves no trace. State uses non-blocking assignments so all
  // registers update together from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_cout  <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      carry_q   <= 1'b0;
      idx       <= '0;
    end else begin
      state    <= next_state;
      // Registered ready: rises on the edge that returns the FSM to IDLE.
      in_ready <= (next_state == IDLE);
      case (state)
        IDLE: begin
          if (accept) begin
            a_q     <= in_a;
            b_q     <= in_b;
            carry_q <= in_cin;
            idx     <= '0;
          end
        end
        ADD: begin
          out_sum[idx*SLICE_W +: SLICE_W] <= slice_s;
          carry_q <= slice_cout;
          idx     <= idx + 1'b1;
          if (last_chunk) begin
            out_cout  <= slice_cout;
            out_valid <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) out_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fa_3_seq_ctrl.sv
module tb_fa_3_seq_ctrl;

  localparam int NCHUNK = 4;
  localparam int W      = 3 * NCHUNK;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a, in_b;
  logic         in_cin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_sum;
  logic         out_cout;
  logic         busy;

  int total = 0;
  int bad   = 0;

  int cyc = 0;
  int accepts = 0;
  int results = 0;
  int last_acc_cyc = 0;
  int last_gap = 0;
  int dropped = 0;

  fa_3_seq_ctrl #(.NCHUNK(NCHUNK)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_cin    (in_cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_cout  (out_cout),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Handshake monitor: inputs only change away from posedge.
  always @(posedge clk) begin
    cyc++;
    if (rst_n) begin
      if (in_valid && in_ready) begin
        accepts++;
        last_gap     = cyc - last_acc_cyc;
        last_acc_cyc = cyc;
      end
      if (out_valid && out_ready) results++;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // One full operation: offer operands, wait for result, optional backpressure.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic cin, input int stall);
    logic [W:0]   exp;
    logic [W-1:0] held_sum;
    logic         held_cout;
    int n;
    int lat;
    exp = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
    @(negedge clk);
    in_a = a; in_b = b; in_cin = cin; in_valid = 1'b1;
    out_ready = (stall == 0);
    n = 0;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("ready_timeout", 32'(n < 20), 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_a = W'($urandom); in_b = W'($urandom); in_cin = 1'($urandom);
    check("busy_add", 32'(busy), 1);
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("latency", lat, NCHUNK);
    check("sum", 32'(out_sum), 32'(exp[W-1:0]));
    check("cout", 32'(out_cout), 32'(exp[W]));
    held_sum  = out_sum;
    held_cout = out_cout;
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      in_valid = i[0];
      in_a = W'($urandom); in_b = W'($urandom);
      check("stall_valid", 32'(out_valid), 1);
      check("stall_sum", 32'(out_sum), 32'(held_sum));
      check("stall_cout", 32'(out_cout), 32'(held_cout));
      check("stall_in_ready", 32'(in_ready), 0);
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("valid_drop", 32'(out_valid), 0);
    check("ready_back", 32'(in_ready), 1);
    check("busy_idle", 32'(busy), 0);
    out_ready = 1'b0;
  endtask

  initial begin
    int n;
    int seen;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_a = '0; in_b = '0; in_cin = 1'b0;

    // Reset applied before any clock edge must already clear the outputs.
    #2;
    check("rst_in_ready", 32'(in_ready), 0);
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_out_sum", 32'(out_sum), 0);
    check("rst_out_cout", 32'(out_cout), 0);
    check("rst_busy", 32'(busy), 0);
    #10;
    rst_n = 1'b1;
    #1;
    check("ready_before_edge", 32'(in_ready), 0);
    @(posedge clk);
    #1;
    check("ready_after_edge", 32'(in_ready), 1);

    // Directed arithmetic.
    run_op(12'h0FF, 12'h001, 1'b0, 0);
    run_op(12'hFFF, 12'h000, 1'b1, 0);
    run_op(12'h7A5, 12'h85B, 1'b0, 0);

    // Backpressure with ignored in_valid pulses.
    run_op(12'hABC, 12'h123, 1'b1, 6);

    // Reset while idx==2: drop the op, outputs clear at once.
    @(negedge clk);
    in_a = 12'h555; in_b = 12'h222; in_cin = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b0;
    dropped++;
    #1;
    check("midrst_valid", 32'(out_valid), 0);
    check("midrst_sum", 32'(out_sum), 0);
    check("midrst_ready", 32'(in_ready), 0);
    check("midrst_busy", 32'(busy), 0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (8) begin
      @(posedge clk);
      #1;
      if (out_valid) seen++;
    end
    check("dropped_no_valid", seen, 0);
    run_op(12'h123, 12'h456, 1'b1, 0);

    // Back-to-back throughput: in_valid held, out_ready held.
    @(negedge clk);
    in_a = 12'h001; in_b = 12'h002; in_cin = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    n = accepts;
    seen = 0;
    while (accepts < n + 3 && seen < 100) begin
      @(negedge clk);
      seen++;
    end
    check("b2b_timeout", 32'(seen < 100), 1);
    check("throughput_gap", last_gap, NCHUNK + 2);
    in_valid = 1'b0;
    seen = 0;
    while (busy && seen < 20) begin
      @(negedge clk);
      seen++;
    end
    check("b2b_drain", 32'(busy), 0);
    check("b2b_sum", 32'(out_sum), 32'h003);
    out_ready = 1'b0;

    // Randomised operations against the a+b+cin model.
    for (int k = 0; k < 2000; k++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      run_op(W'($urandom), W'($urandom), 1'($urandom), $urandom_range(0, 3));
    end

    repeat (3) @(posedge clk);
    #1;
    check("one_result_per_accept", results, accepts - dropped);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fa_3_seq_ctrl.md
Name: fa_3_seq_ctrl

Overview:
Multi-cycle wide adder controller. It time-multiplexes a single fa_3 3-bit slice to add two NCHUNK*3-bit operands, one chunk per clock, LSB chunk first. The carry is chained through a register between chunks. Upstream and downstream connect through valid/ready handshakes, so the block can replace a wide ripple adder where area matters more than throughput.

Parameters:
NCHUNK, 4, number of 3-bit chunks per operand; legal range 1..16.
W, 3*NCHUNK, operand/sum width; derived, not overridable.

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  reset; asynchronous, active-low
in_valid  in  1  operand request
in_ready  out  1  block can accept operands (registered)
in_a  in  W  operand A
in_b  in  W  operand B
in_cin  in  1  carry-in
out_valid  out  1  result available (registered)
out_ready  in  1  downstream accepts result
out_sum  out  W  sum, registered
out_cout  out  1  carry-out of the MSB chunk, registered
busy  out  1  high in ADD or DONE (combinational from state)

Behaviour:
- One clock domain: clk. Reset is asynchronous and active-low on rst_n, applied to all flops.
- Reset values:
  - state=IDLE, in_ready=0, out_valid=0, out_sum=0, out_cout=0.
  - Internal registers a_q, b_q, carry_q and idx all 0.
- in_ready is a register:
  - Next value = (next_state==IDLE).
  - It therefore first rises on the first clk edge after rst_n deasserts.
- IDLE:
  - Accept when in_valid && in_ready.
  - On acceptance: a_q<=in_a, b_q<=in_b, carry_q<=in_cin, idx<=0. Go to ADD.
- ADD:
  - fa_3 inputs: a_q[idx*3+:3], b_q[idx*3+:3], carry_q.
  - Each edge: out_sum[idx*3+:3]<=s, carry_q<=cout, idx<=idx+1.
  - When idx==NCHUNK-1: out_cout<=cout, out_valid<=1, go to DONE.
- DONE:
  - out_valid, out_sum and out_cout are held stable.
  - When out_ready is high: out_valid<=0, go to IDLE. in_ready returns high on the same edge.
- Latency: out_valid rises exactly NCHUNK clk edges after the accept edge.
- Throughput: one operation per NCHUNK+2 cycles at best. Accept and complete never overlap.
- in_valid is ignored while in_ready=0. Operands are sampled only on the accept edge, so later input changes have no effect.
- out_sum holds the previous result until overwritten chunk-by-chunk during the next ADD. Only out_valid qualifies it.
- Arithmetic: {out_cout,out_sum} == in_a + in_b + in_cin, unsigned, W+1 bits. Wrap is modulo 2^W, and the overflow appears only on out_cout.
- NCHUNK=1: ADD lasts exactly one cycle.
- Reset mid-operation (any state): the in-flight operation is dropped and all outputs return to their reset values immediately. No out_valid is produced for the dropped operation.
- out_ready while not in DONE: ignored.

Decomposition:
- Package fa_3_seq_pkg holds:
  - SLICE_W=3.
  - typedef enum logic [1:0] {IDLE, ADD, DONE} seq_state_t.
  - The idx width function clog2(NCHUNK) (minimum 1).
- Sub-module: exactly one instance of the existing fa_3, port order (a,b,cin,s,cout). The controller contains no other arithmetic apart from the idx increment.

Test Plan (NCHUNK=4, W=12):
1. Reset: hold rst_n=0 mid-clock -> outputs go to 0 with no clk edge needed. Release -> in_ready=1 after the first edge.
2. a=12'h0FF, b=12'h001, cin=0, out_ready=1 -> out_sum=12'h100, out_cout=0. out_valid high exactly 4 edges after accept, for 1 cycle.
3. a=12'hFFF, b=12'h000, cin=1 (full-ripple carry) -> out_sum=12'h000, out_cout=1. a=12'h7A5, b=12'h85B, cin=0 -> out_sum=12'h000, out_cout=1.
4. Backpressure: out_ready=0 for 6 cycles after out_valid -> out_valid, out_sum and out_cout stable. in_ready=0, and in_valid pulses are ignored (no capture). Result completes on the edge where out_ready=1.
5. Reset mid-op: assert rst_n=0 while idx==2 -> no out_valid. Next op a=12'h123, b=12'h456, cin=1 -> out_sum=12'h57A, cout=0.
6. Random: 2000 ops with random in_valid/out_ready gaps, checked against the a+b+cin scoreboard. Also check the latency and throughput counts, and that every accepted op yields exactly one result.
